// File: rtl/dice_move_if.sv
// Move-command handshake between the turn controller and the game logic.
//   move_valid  : command valid (controller -> game)
//   move_ready  : game accepts the command (game -> controller)
//   move_player : player the move belongs to
//   move_steps  : step count, 1..3
interface dice_move_if #(
  parameter int unsigned PW = 1
);
  logic          move_valid;
  logic          move_ready;
  logic [PW-1:0] move_player;
  logic [1:0]    move_steps;

  modport master (output move_valid, output move_player, output move_steps, input move_ready);
  modport slave  (input move_valid, input move_player, input move_steps, output move_ready);
endinterface

// File: rtl/dice_turn_controller.sv
// Turn scheduler sharing one ROI colour detector among NUM_PLAYERS players.
// Each turn: wait for a clear (white) board, arm for a dice result, issue the
// move over a valid/ready handshake, then wait for the dice to be removed.
// An idle turn is skipped after TIMEOUT_FRAMES frames in ARMED (0 = never).
// Optional feature macro: DICE_BONUS_TURN_EN (accepted BLUE keeps the player).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   frame_tick            : one-cycle pulse per video frame
//   start / abort         : start pulse (IDLE only) / abort level (any state)
//   stable_color          : 00 NONE, 01 RED, 10 GREEN, 11 BLUE
//   result_ready          : stable_color valid this cycle
//   current_state_white   : white background detected
//   move                  : move command handshake (master side)
//   cur_player            : player whose turn is active
//   turn_count            : completed turns, wraps at 8 bits
//   timeout_pulse         : one cycle when a turn is skipped
//   busy                  : high outside IDLE
module dice_turn_controller #(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned TIMEOUT_FRAMES = 600,
  localparam int unsigned PW = (NUM_PLAYERS <= 2) ? 1 : $clog2(NUM_PLAYERS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        stable_color,
  input  logic              result_ready,
  input  logic              current_state_white,
  dice_move_if.master       move,
  output logic [PW-1:0]     cur_player,
  output logic [7:0]        turn_count,
  output logic              timeout_pulse,
  output logic              busy
);

  localparam int unsigned CW = 16;
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_WHITE = 3'd1;
  localparam logic [2:0] S_ARMED      = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_CLEAR      = 3'd4;

  localparam logic [CW-1:0] TO_LIMIT    = CW'(TIMEOUT_FRAMES);
  localparam logic          TO_EN       = (TIMEOUT_FRAMES != 0);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [1:0]    COLOR_NONE  = 2'b00;
  localparam logic [1:0]    COLOR_BLUE  = 2'b11;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  logic          move_valid_q, move_valid_d;
  logic [PW-1:0] move_player_q, move_player_d;
  logic [1:0]    move_steps_q, move_steps_d;
  logic [PW-1:0] cur_player_q, cur_player_d, next_player;
  logic [7:0]    turn_count_q, turn_count_d;
  logic          timeout_pulse_q, timeout_pulse_d;
  logic          busy_q, busy_d;
  logic          timeout_hit;
  logic          keep_player;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      frame_cnt_q     <= '0;
      move_valid_q    <= 1'b0;
      move_player_q   <= '0;
      move_steps_q    <= 2'd0;
      cur_player_q    <= '0;
      turn_count_q    <= 8'd0;
      timeout_pulse_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      move_valid_q    <= move_valid_d;
      move_player_q   <= move_player_d;
      move_steps_q    <= move_steps_d;
      cur_player_q    <= cur_player_d;
      turn_count_q    <= turn_count_d;
      timeout_pulse_q <= timeout_pulse_d;
      busy_q          <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    frame_cnt_d     = frame_cnt_q;
    move_player_d   = move_player_q;
    move_steps_d    = move_steps_q;
    cur_player_d    = cur_player_q;
    turn_count_d    = turn_count_q;
    timeout_pulse_d = 1'b0;

    // Saturating frame count; the timeout fires in the cycle of the tick
    // that brings the count up to the limit.
    frame_cnt_inc = (frame_cnt_q == {CW{1'b1}}) ? frame_cnt_q : frame_cnt_q + CW'(1);
    timeout_hit   = TO_EN && frame_tick && (frame_cnt_inc >= TO_LIMIT);
    next_player   = (cur_player_q == LAST_PLAYER) ? '0 : cur_player_q + PW'(1);

`ifdef DICE_BONUS_TURN_EN
    keep_player = (move_steps_q == COLOR_BLUE);
`else
    keep_player = 1'b0;
`endif

    if (abort) begin
      state_d     = S_IDLE;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_cnt_d = '0;
          if (start) begin
            state_d      = S_WAIT_WHITE;
            cur_player_d = '0;
            turn_count_d = 8'd0;
          end
        end
        S_WAIT_WHITE: begin
          frame_cnt_d = '0;
          if (current_state_white) state_d = S_ARMED;
        end
        S_ARMED: begin
          // A valid result beats a coincident timeout.
          if (result_ready && (stable_color != COLOR_NONE)) begin
            move_player_d = cur_player_q;
            move_steps_d  = stable_color;
            state_d       = S_ISSUE;
          end else if (timeout_hit) begin
            timeout_pulse_d = 1'b1;
            cur_player_d    = next_player;
            turn_count_d    = turn_count_q + 8'd1;
            frame_cnt_d     = '0;
            state_d         = S_WAIT_WHITE;
          end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_inc;
          end
        end
        S_ISSUE: begin
          // move_valid is high throughout ISSUE, so ready alone completes it.
          if (move.move_ready) begin
            turn_count_d = turn_count_q + 8'd1;
            state_d      = S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (current_state_white) begin
            if (!keep_player) cur_player_d = next_player;
            frame_cnt_d = '0;
            state_d     = S_ARMED;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    move_valid_d = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
  end

  assign move.move_valid  = move_valid_q;
  assign move.move_player = move_player_q;
  assign move.move_steps  = move_steps_q;
  assign cur_player       = cur_player_q;
  assign turn_count       = turn_count_q;
  assign timeout_pulse    = timeout_pulse_q;
  assign busy             = busy_q;

endmodule

// File: doc/dice_turn_controller.md
# dice_turn_controller

Turn scheduler that shares the single ROI colour detector among `NUM_PLAYERS` players of the dice race game. It sequences each turn through four steps: board clear (white), dice roll detected, move issued, dice removed. It converts the detector's stable colour result into a step-count move command for the game logic. A valid/ready handshake carries the command, and a per-turn frame timeout skips an idle player.

## Interface
- `NUM_PLAYERS`, 2 — players in rotation, 2..4.
- `TIMEOUT_FRAMES`, 600 — frames allowed in ARMED before the turn is skipped; 0 disables the timeout.
- `PW`, derived — player index width, `$clog2(NUM_PLAYERS)`, minimum 1.

- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-high.
- `frame_tick` in 1 — one-cycle pulse per video frame.
- `start` in 1 — pulse; begins the game from IDLE.
- `abort` in 1 — level; forces IDLE from any state.
- `stable_color` in 2 — 00=NONE, 01=RED, 10=GREEN, 11=BLUE.
- `result_ready` in 1 — pulse; `stable_color` is valid this cycle.
- `current_state_white` in 1 — level; white background currently detected.
- `move_valid` out 1 — move command valid.
- `move_ready` in 1 — game logic accepts the move.
- `move_player` out PW — player the move belongs to.
- `move_steps` out 2 — RED=1, GREEN=2, BLUE=3.
- `cur_player` out PW — player whose turn is active.
- `turn_count` out 8 — completed turns (moves accepted plus timeouts); wraps 255→0.
- `timeout_pulse` out 1 — one cycle when a turn is skipped.
- `busy` out 1 — high in every state except IDLE.

## Operation
- States: IDLE, WAIT_WHITE, ARMED, ISSUE, CLEAR.
- **IDLE**
  - On `start` → WAIT_WHITE; `cur_player`=0, `turn_count`=0.
  - `start` outside IDLE is ignored.
- **WAIT_WHITE** (board must be clear before a roll counts)
  - When `current_state_white`=1 → ARMED.
  - Timeout counter is cleared.
- **ARMED**
  - Each `frame_tick` increments the 16-bit frame counter.
  - `result_ready`=1 with `stable_color`≠NONE:
    - Latch player and steps into the move registers.
    - → ISSUE.
  - `result_ready` with NONE is ignored.
  - Counter reaching `TIMEOUT_FRAMES` (when nonzero):
    - `timeout_pulse`=1 for one cycle.
    - Advance `cur_player`, increment `turn_count`.
    - → WAIT_WHITE.
  - If `result_ready` and the timeout occur in the same cycle, the result wins; no timeout is raised.
- **ISSUE**
  - `move_valid`=1; `move_player` and `move_steps` stay stable until the transfer.
  - Transfer happens in the cycle with `move_valid`&&`move_ready`.
  - After the transfer: increment `turn_count`, → CLEAR.
  - No timeout applies in ISSUE; back-pressure may last indefinitely.
- **CLEAR** (dice removed)
  - When `current_state_white`=1:
    - Advance `cur_player` as (p+1) mod `NUM_PLAYERS`, wrapping from `NUM_PLAYERS`-1 to 0.
    - → ARMED with the counter cleared.
- **Abort**
  - `abort`=1 in any state → IDLE next cycle.
  - An in-flight `move_valid` drops without a transfer; `cur_player` and `turn_count` are held.
  - `abort` takes priority over every other event.
- Detector results arriving outside ARMED are discarded.

## Timing
- **Reset values**:
  - State IDLE.
  - `move_valid`=0, `move_player`=0, `move_steps`=0.
  - `cur_player`=0, `turn_count`=0.
  - `timeout_pulse`=0, `busy`=0.
  - Frame counter 0.
- All outputs are registered.
- **Latencies**:
  - `result_ready` sampled in ARMED at cycle N → `move_valid`=1 at N+1.
  - Transfer at cycle M → `move_valid`=0 and `turn_count` updated at M+1.
  - White seen in CLEAR at cycle K → `cur_player` updated and state ARMED at K+1.
  - Timeout detected at cycle T → `timeout_pulse` is high during T+1 only, coincident with the `cur_player` update.
- The frame counter saturates at 0xFFFF.
- `move_ready` may be high before `move_valid`; the transfer then completes in the first ISSUE cycle.

## Configuration
- `DICE_BONUS_TURN_EN`
  - Defined: a BLUE move that is accepted keeps the same player.
    - CLEAR → ARMED without advancing `cur_player`.
    - `turn_count` still increments.
  - Undefined: every accepted move advances the player; BLUE is treated like any other colour apart from its step value.

## Test plan
- **Basic sequence**: reset, `start`, white=1, `result_ready` with GREEN, `move_ready`=1.
  - `move_valid` one cycle after the result, carrying `move_player`=0, `move_steps`=2.
  - After white: `cur_player`=1, `turn_count`=1.
- **Back-pressure**: RED result with `move_ready`=0 for 20 cycles, then 1.
  - `move_valid` held 20+ cycles with fields stable (`move_steps`=1); exactly one transfer.
- **Timeout**: `TIMEOUT_FRAMES`=4, ARMED, 4 `frame_tick`s and no result.
  - One-cycle `timeout_pulse`, `cur_player` 0→1, state WAIT_WHITE, `turn_count`=1.
  - Result coincident with the 4th tick → move issued, no `timeout_pulse`.
- **Player wrap and NONE filtering**: `NUM_PLAYERS`=3, three completed turns.
  - `cur_player` sequence 0,1,2,0.
  - A `result_ready` with NONE in ARMED produces no `move_valid`.
- **Abort**: `abort` during ISSUE with `move_ready`=0.
  - `move_valid`=0 the next cycle, `busy`=0, `turn_count` unchanged; a later `start` resets `cur_player` to 0.
- **Bonus turn**: with `DICE_BONUS_TURN_EN` defined, accepted BLUE move (`move_steps`=3).
  - `cur_player` unchanged after CLEAR.
  - Without the macro, `cur_player` advances.
